// File: rtl/hex_step_counter.sv
// hex_step_counter: button-stepped up/down counter over [MIN_VAL, MAX_VAL] with decimal seven-segment output.
// Optional debounce stage is built when HEX_STEP_COUNTER_DEBOUNCE_EN is defined.
module hex_step_counter #(
  parameter int DIGITS    = 2,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 5,
  parameter int WRAP      = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic                             CLOCK_50,
  input  logic                             RESET_N,
  input  logic                             STEP_N,
  input  logic                             CLEAR_N,
  input  logic [9:0]                       SW,
  output logic [7*DIGITS-1:0]              HEX,
  output logic [$clog2(MAX_VAL+1)-1:0]     COUNT,
  output logic                             ERR,
  output logic                             WRAP_PULSE
);
  localparam int CW = $clog2(MAX_VAL + 1);
  localparam int BW = 4 * DIGITS;

  // Binary to BCD (double-dabble), then per-digit segments with leading-zero blanking and error dashes.
  function automatic logic [7*DIGITS-1:0] hex_of(input logic [CW-1:0] v, input logic e);
    logic [BW-1:0] bcd;
    logic          lead;
    logic [3:0]    d;
    logic [6:0]    seg;
    hex_of = '0;
    bcd    = '0;
    lead   = 1'b1;
    for (int i = CW - 1; i >= 0; i--) begin
      for (int k = 0; k < DIGITS; k++)
        if (bcd[4*k +: 4] >= 4'd5) bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      bcd = {bcd[BW-2:0], v[i]};
    end
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d = bcd[4*k +: 4];
      case (d)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b0111111;
      endcase
      lead = lead & (d == 4'd0) & (k != 0);
      hex_of[7*k +: 7] = e ? 7'b0111111 : (lead ? 7'b1111111 : seg);
    end
  endfunction

  logic          r_sync0, r_sync1, r_prev, r_armed;
  logic [1:0]    r_vld;
  logic          w_lvl, w_step;
  logic [CW-1:0] r_count, w_count_nx;
  logic          r_err, w_err_nx, r_wrap, w_wrap_nx;
  logic [7*DIGITS-1:0] r_hex;
  logic [CW:0]   w_ext;

  // Two-flop synchroniser; arming waits until the button has really been seen released after reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync0 <= STEP_N;
      r_sync1 <= r_sync0;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & r_sync1);
    end
  end

`ifdef HEX_STEP_COUNTER_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  logic          r_db;
  logic [DW-1:0] r_db_cnt;

  // Debounced level follows the synchronised level only after DB_CYCLES consecutive differing cycles.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_db     <= 1'b1;
      r_db_cnt <= '0;
    end else if (r_sync1 == r_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DW'(DB_CYCLES - 1)) begin
      r_db     <= r_sync1;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DW'(1);
    end
  end

  assign w_lvl = r_db;
`else
  logic w_unused_db;
  assign w_unused_db = DB_CYCLES[0];
  assign w_lvl       = r_sync1;
`endif

  // Registered copy of the level for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_prev <= 1'b1;
    else          r_prev <= w_lvl;
  end

  assign w_step = r_armed & r_prev & ~w_lvl;
  assign w_ext  = {1'b0, r_count};

  // Next count/error/wrap on a step event: clear, then illegal switches, then up/down step.
  always_comb begin
    w_count_nx = r_count;
    w_err_nx   = r_err;
    w_wrap_nx  = 1'b0;
    if (w_step) begin
      if (!CLEAR_N) begin
        w_count_nx = CW'(MIN_VAL);
        w_err_nx   = 1'b0;
      end else if (|SW[9:1]) begin
        w_err_nx = 1'b1;
      end else begin
        w_err_nx = 1'b0;
        if (SW[0]) begin
          if (w_ext < (CW+1)'(MAX_VAL)) begin
            w_count_nx = CW'(w_ext + (CW+1)'(1));
          end else if (WRAP != 0) begin
            w_count_nx = CW'(MIN_VAL);
            w_wrap_nx  = 1'b1;
          end
        end else begin
          if (w_ext > (CW+1)'(MIN_VAL)) begin
            w_count_nx = CW'(w_ext - (CW+1)'(1));
          end else if (WRAP != 0) begin
            w_count_nx = CW'(MAX_VAL);
            w_wrap_nx  = 1'b1;
          end
        end
      end
    end
  end

  // Counter state and one-cycle wrap pulse.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= CW'(MIN_VAL);
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nx;
      r_err   <= w_err_nx;
      r_wrap  <= w_wrap_nx;
    end
  end

  // Display register, one cycle behind the count.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_hex <= hex_of(CW'(MIN_VAL), 1'b0);
    else          r_hex <= hex_of(r_count, r_err);
  end

  assign HEX        = r_hex;
  assign COUNT      = r_count;
  assign ERR        = r_err;
  assign WRAP_PULSE = r_wrap;
endmodule

// File: tb/tb_hex_step_counter.sv
// tb_hex_step_counter: scoreboard bench for three hex_step_counter configurations.
module tb_hex_step_counter;
`ifdef HEX_STEP_COUNTER_DEBOUNCE_EN
  localparam int HOLD = 16 + 8;
`else
  localparam int HOLD = 4;
`endif
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;

  logic clk = 1'b0, rst_n = 1'b0, sa = 1'b1, sb = 1'b1, sc = 1'b1, clr_n = 1'b1;
  logic [9:0]  sw = '0;
  logic [13:0] hex_a, hex_b, hex_c;
  logic [2:0]  cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        err_a, err_b, err_c, wp_a, wp_b, wp_c;
  logic [6:0]  S [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int nw [3] = '{0, 0, 0};
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int          id;
    int          cnt;
    logic        err;
    logic [13:0] hex;
    int          wraps;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hex_step_counter #(.WRAP(1)) ua (.CLOCK_50(clk), .RESET_N(rst_n), .STEP_N(sa), .CLEAR_N(clr_n),
    .SW(sw), .HEX(hex_a), .COUNT(cnt_a), .ERR(err_a), .WRAP_PULSE(wp_a));
  hex_step_counter #(.WRAP(0)) ub (.CLOCK_50(clk), .RESET_N(rst_n), .STEP_N(sb), .CLEAR_N(clr_n),
    .SW(sw), .HEX(hex_b), .COUNT(cnt_b), .ERR(err_b), .WRAP_PULSE(wp_b));
  hex_step_counter #(.MIN_VAL(0), .MAX_VAL(12)) uc (.CLOCK_50(clk), .RESET_N(rst_n), .STEP_N(sc),
    .CLEAR_N(clr_n), .SW(sw), .HEX(hex_c), .COUNT(cnt_c), .ERR(err_c), .WRAP_PULSE(wp_c));

  task automatic chk(input string n, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic expect_(input int id, input int cnt, input logic err, input logic [13:0] hex, input int wraps);
    exp_t e;
    e.id = id; e.cnt = cnt; e.err = err; e.hex = hex; e.wraps = wraps;
    q.push_back(e);
  endtask

  task automatic drive(input int id, input logic v);
    if (id == 0) sa = v;
    else if (id == 1) sb = v;
    else sc = v;
  endtask

  task automatic press(input int id);
    @(posedge clk); #1;
    drive(id, 1'b0);
    repeat (HOLD) @(posedge clk);
    #1 drive(id, 1'b1);
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  // Monitor: counts wrap-pulse cycles and compares every pending expectation against the DUT.
  always @(negedge clk) begin
    exp_t e;
    if (wp_a) nw[0]++;
    if (wp_b) nw[1]++;
    if (wp_c) nw[2]++;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("dut%0d count", e.id), e.id == 0 ? int'(cnt_a) : e.id == 1 ? int'(cnt_b) : int'(cnt_c), e.cnt);
      chk($sformatf("dut%0d err", e.id), e.id == 0 ? int'(err_a) : e.id == 1 ? int'(err_b) : int'(err_c), int'(e.err));
      chk($sformatf("dut%0d hex", e.id), e.id == 0 ? int'(hex_a) : e.id == 1 ? int'(hex_b) : int'(hex_c), int'(e.hex));
      chk($sformatf("dut%0d wraps", e.id), nw[e.id], e.wraps);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    expect_(0, 1, 1'b0, {BL, S[1]}, 0);
    expect_(1, 1, 1'b0, {BL, S[1]}, 0);
    expect_(2, 0, 1'b0, {BL, S[0]}, 0);
    sw = 10'h001;
    for (int i = 1; i <= 5; i++) begin
      press(0);
      expect_(0, i < 5 ? i + 1 : 1, 1'b0, {BL, S[i < 5 ? i + 1 : 1]}, i < 5 ? 0 : 1);
    end
    sw = 10'h000;
    press(0);
    expect_(0, 5, 1'b0, {BL, S[5]}, 2);
    press(1);
    expect_(1, 1, 1'b0, {BL, S[1]}, 0);
    press(0);
    expect_(0, 4, 1'b0, {BL, S[4]}, 2);
    sw = 10'h201;
    press(0);
    expect_(0, 4, 1'b1, {DA, DA}, 2);
    sw = 10'h001;
    press(0);
    expect_(0, 5, 1'b0, {BL, S[5]}, 2);
    for (int i = 1; i <= 10; i++) begin
      press(2);
      expect_(2, i, 1'b0, i < 10 ? {BL, S[i]} : {S[1], S[0]}, 0);
    end
    clr_n = 1'b0;
    press(2);
    clr_n = 1'b1;
    expect_(2, 0, 1'b0, {BL, S[0]}, 0);
    clr_n = 1'b0;
    sw = 10'h3FF;
    repeat (HOLD) @(posedge clk);
    #1 sw = 10'h001;
    clr_n = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 expect_(2, 0, 1'b0, {BL, S[0]}, 0);
    sw = 10'h000;
    press(2);
    expect_(2, 12, 1'b0, {S[1], S[2]}, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sa = 1'b0;
    expect_(0, 1, 1'b0, {BL, S[1]}, 2);
    expect_(2, 0, 1'b0, {BL, S[0]}, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (HOLD + 4) @(posedge clk);
    #1 expect_(0, 1, 1'b0, {BL, S[1]}, 2);
    sa = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 expect_(0, 1, 1'b0, {BL, S[1]}, 2);
    sw = 10'h001;
    press(0);
    expect_(0, 2, 1'b0, {BL, S[2]}, 2);
`ifdef HEX_STEP_COUNTER_DEBOUNCE_EN
    @(posedge clk);
    #1 sa = 1'b0;
    repeat (5) @(posedge clk);
    #1 sa = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 expect_(0, 2, 1'b0, {BL, S[2]}, 2);
    press(0);
    expect_(0, 3, 1'b0, {BL, S[3]}, 2);
`endif
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
